pin_motion: RTL and testbench

PIN_MOTION -- requirements
Module: pin_motion

---
 rtl/physics_pkg.sv | 20 ++
 rtl/pin_integrate.sv | 46 ++++
 rtl/pin_motion.sv | 170 +++++++++++++++++
 tb/tb_pin_motion.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/physics_pkg.sv
// Shared constants and types for the pin physics stage: lane geometry,
// fixed-point format, starting rack and the integration FSM states.
package physics_pkg;

    localparam int PIN_COUNT     = 10;
    localparam int SCREEN_WIDTH  = 1024;
    localparam int SCREEN_HEIGHT = 768;
    localparam int FRAC_BITS     = 8;

    // Rack positions in whole pixels, head pin first, back row last.
    localparam int RACK_X [PIN_COUNT] = '{512, 488, 536, 464, 512, 560, 440, 488, 536, 584};
    localparam int RACK_Y [PIN_COUNT] = '{200, 158, 158, 116, 116, 116,  74,  74,  74,  74};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        DONE   = 2'd2
    } motion_state_t;

endpackage

// File: rtl/pin_integrate.sv
// Combinational single-pin step: move by the current velocity, then apply
// friction and the deadband, and flag a pin that has left the lane.
module pin_integrate
    import physics_pkg::*;
#(
    parameter int FRICTION_SHIFT = 4,
    parameter int VEL_DEADBAND   = 16
) (
    input  logic [18:0]        px,
    input  logic [17:0]        py,
    input  logic signed [15:0] vx,
    input  logic signed [15:0] vy,
    output logic [18:0]        px_new,
    output logic [17:0]        py_new,
    output logic signed [15:0] vx_new,
    output logic signed [15:0] vy_new,
    output logic               off
);

    localparam logic signed [20:0] X_LIMIT = 21'(SCREEN_WIDTH << FRAC_BITS);
    localparam logic signed [20:0] Y_LIMIT = 21'(SCREEN_HEIGHT << FRAC_BITS);

    logic signed [20:0] sx;
    logic signed [20:0] sy;

    // Friction removes a fixed fraction; tiny residual speeds snap to rest.
    function automatic logic signed [15:0] decay(input logic signed [15:0] v);
        logic signed [15:0] d;
        logic [15:0]        mag;
        d   = v - (v >>> FRICTION_SHIFT);
        mag = d[15] ? 16'(-d) : 16'(d);
        return (mag < 16'(VEL_DEADBAND)) ? 16'sd0 : d;
    endfunction

    // Position moves by the pre-decay velocity at a width that cannot wrap.
    always_comb begin
        sx     = $signed({2'b00, px}) + 21'(vx);
        sy     = $signed({3'b000, py}) + 21'(vy);
        px_new = sx[18:0];
        py_new = sy[17:0];
        vx_new = decay(vx);
        vy_new = decay(vy);
        off    = (sx < 21'sd0) || (sx >= X_LIMIT) || (sy < 21'sd0) || (sy >= Y_LIMIT);
    end

endmodule

// File: rtl/pin_motion.sv
// Pin motion integrator: captures post-collision velocities and, once per
// frame, walks the ten pins through one shared integrate step.
// Handshake: done_in and frame_tick are single-cycle pulses with no ready;
// done_in is always accepted, frame_tick only while idle; valid_out pulses
// for one cycle when all ten pins have been stepped.
module pin_motion
    import physics_pkg::*;
#(
    parameter int FRICTION_SHIFT = 4,
    parameter int VEL_DEADBAND   = 16
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               done_in,
    input  logic [9:0]         hit_in,
    input  logic [9:0][15:0]   vx_in,
    input  logic [9:0][15:0]   vy_in,
    input  logic               frame_tick,
    output logic [9:0][10:0]   pins_x,
    output logic [9:0][9:0]    pins_y,
    output logic [9:0][15:0]   pins_vx,
    output logic [9:0][15:0]   pins_vy,
    output logic [9:0]         pins_down,
    output logic               busy,
    output logic               valid_out,
    output motion_state_t      state_dbg
);

    motion_state_t      state, state_nx;
    logic [3:0]         idx, idx_nx;
    logic               busy_q, valid_q;

    logic [18:0]        pos_x [PIN_COUNT];
    logic [17:0]        pos_y [PIN_COUNT];
    logic signed [15:0] vel_x [PIN_COUNT];
    logic signed [15:0] vel_y [PIN_COUNT];
    logic signed [15:0] cap_x [PIN_COUNT];
    logic signed [15:0] cap_y [PIN_COUNT];
    logic [9:0]         pend;
    logic [9:0]         down;

    logic               upd_en;
    logic signed [15:0] cur_vx, cur_vy;
    logic [18:0]        nx;
    logic [17:0]        ny;
    logic signed [15:0] nvx, nvy;
    logic               off;

    // Next-state and pin index sequencing for one integration pass.
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        case (state)
            IDLE: begin
                if (frame_tick) begin
                    state_nx = UPDATE;
                    idx_nx   = 4'd0;
                end
            end
            UPDATE: begin
                if (idx == 4'(PIN_COUNT - 1)) begin
                    state_nx = DONE;
                    idx_nx   = 4'd0;
                end else begin
                    idx_nx = idx + 4'd1;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register; busy and valid_out are registered from the next state.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state   <= IDLE;
            idx     <= 4'd0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_nx;
            idx     <= idx_nx;
            busy_q  <= (state_nx != IDLE);
            valid_q <= (state_nx == DONE);
        end
    end

    // Select the pin under update; a pending capture replaces its velocity.
    always_comb begin
        upd_en = (state == UPDATE) && !down[idx];
        cur_vx = pend[idx] ? cap_x[idx] : vel_x[idx];
        cur_vy = pend[idx] ? cap_y[idx] : vel_y[idx];
    end

    pin_integrate #(
        .FRICTION_SHIFT (FRICTION_SHIFT),
        .VEL_DEADBAND   (VEL_DEADBAND)
    ) u_integrate (
        .px     (pos_x[idx]),
        .py     (pos_y[idx]),
        .vx     (cur_vx),
        .vy     (cur_vy),
        .px_new (nx),
        .py_new (ny),
        .vx_new (nvx),
        .vy_new (nvy),
        .off    (off)
    );

    // Capture registers; a same-cycle capture overrides the update's clear.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pend <= '0;
            for (int i = 0; i < PIN_COUNT; i++) begin
                cap_x[i] <= 16'sd0;
                cap_y[i] <= 16'sd0;
            end
        end else begin
            for (int i = 0; i < PIN_COUNT; i++) begin
                if (upd_en && (idx == 4'(i))) begin
                    pend[i] <= 1'b0;
                end
                if (done_in && hit_in[i] && !down[i]) begin
                    pend[i]  <= 1'b1;
                    cap_x[i] <= vx_in[i];
                    cap_y[i] <= vy_in[i];
                end
            end
        end
    end

    // Pin state: written only in the owning pin's update cycle.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            down <= '0;
            for (int i = 0; i < PIN_COUNT; i++) begin
                pos_x[i] <= 19'(RACK_X[i] << FRAC_BITS);
                pos_y[i] <= 18'(RACK_Y[i] << FRAC_BITS);
                vel_x[i] <= 16'sd0;
                vel_y[i] <= 16'sd0;
            end
        end else if (upd_en) begin
            if (off) begin
                down[idx]  <= 1'b1;
                pos_x[idx] <= {11'd2047, 8'd0};
                pos_y[idx] <= {10'd1023, 8'd0};
                vel_x[idx] <= 16'sd0;
                vel_y[idx] <= 16'sd0;
            end else begin
                pos_x[idx] <= nx;
                pos_y[idx] <= ny;
                vel_x[idx] <= nvx;
                vel_y[idx] <= nvy;
            end
        end
    end

    for (genvar g = 0; g < PIN_COUNT; g++) begin : g_out
        assign pins_x[g]  = pos_x[g][18:8];
        assign pins_y[g]  = pos_y[g][17:8];
        assign pins_vx[g] = vel_x[g];
        assign pins_vy[g] = vel_y[g];
    end

    assign pins_down = down;
    assign busy      = busy_q;
    assign valid_out = valid_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_pin_motion.sv
// Bench for pin_motion: a per-cycle reference model of the pass schedule
// and pin physics, plus directed scenarios with hand-computed values.
module tb_pin_motion;
    import physics_pkg::*;

    logic               clk_in = 1'b0;
    logic               rst_in = 1'b1;
    logic               done_in = 1'b0;
    logic [9:0]         hit_in = '0;
    logic [9:0][15:0]   vx_in = '0;
    logic [9:0][15:0]   vy_in = '0;
    logic               frame_tick = 1'b0;
    logic [9:0][10:0]   pins_x;
    logic [9:0][9:0]    pins_y;
    logic [9:0][15:0]   pins_vx;
    logic [9:0][15:0]   pins_vy;
    logic [9:0]         pins_down;
    logic               busy;
    logic               valid_out;
    motion_state_t      state_dbg;

    pin_motion dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .done_in    (done_in),
        .hit_in     (hit_in),
        .vx_in      (vx_in),
        .vy_in      (vy_in),
        .frame_tick (frame_tick),
        .pins_x     (pins_x),
        .pins_y     (pins_y),
        .pins_vx    (pins_vx),
        .pins_vy    (pins_vy),
        .pins_down  (pins_down),
        .busy       (busy),
        .valid_out  (valid_out),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk_in = ~clk_in;

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Positions in 1/256 px, velocities in 1/256 px/frame, plain ints.
    int rack_x [10] = '{512, 488, 536, 464, 512, 560, 440, 488, 536, 584};
    int rack_y [10] = '{200, 158, 158, 116, 116, 116,  74,  74,  74,  74};
    int mx [10], my [10], mvx [10], mvy [10], mcx [10], mcy [10];
    bit mpend [10], mdown [10];
    int mstep;           // -1 idle, 0..9 pin being stepped, 10 pass finished
    bit mbusy, mvalid;

    function automatic int friction(input int v);
        int n;
        n = v - (v >>> 4);
        if (n > -16 && n < 16) n = 0;
        return n;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < 10; i++) begin
            mx[i] = rack_x[i] * 256;  my[i] = rack_y[i] * 256;
            mvx[i] = 0; mvy[i] = 0; mcx[i] = 0; mcy[i] = 0;
            mpend[i] = 0; mdown[i] = 0;
        end
        mstep = -1; mbusy = 0; mvalid = 0;
    endfunction

    function automatic void m_clock();
        bit old_down [10];
        int p, vx, vy, nx, ny;
        old_down = mdown;
        p = mstep;
        if (p >= 0 && p <= 9 && !mdown[p]) begin
            vx = mpend[p] ? mcx[p] : mvx[p];
            vy = mpend[p] ? mcy[p] : mvy[p];
            mpend[p] = 0;
            nx = mx[p] + vx;
            ny = my[p] + vy;
            if (nx < 0 || nx >= 1024 * 256 || ny < 0 || ny >= 768 * 256) begin
                mdown[p] = 1;
                mx[p] = 2047 * 256; my[p] = 1023 * 256;
                mvx[p] = 0; mvy[p] = 0;
            end else begin
                mx[p] = nx; my[p] = ny;
                mvx[p] = friction(vx); mvy[p] = friction(vy);
            end
        end
        if (done_in) begin
            for (int i = 0; i < 10; i++) begin
                if (hit_in[i] && !old_down[i]) begin
                    mpend[i] = 1;
                    mcx[i] = int'($signed(vx_in[i]));
                    mcy[i] = int'($signed(vy_in[i]));
                end
            end
        end
        if (mstep == -1) mstep = frame_tick ? 0 : -1;
        else if (mstep == 10) mstep = -1;
        else mstep = mstep + 1;
        mbusy  = (mstep != -1);
        mvalid = (mstep == 10);
    endfunction

    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) m_reset();
        else m_clock();
    end

    // ---------------- compare process ----------------
    initial begin
        logic [15:0] e16;
        forever begin
            @(posedge clk_in);
            #1;
            if (cmp_en) begin
                check("busy", {31'd0, busy}, {31'd0, mbusy});
                check("valid_out", {31'd0, valid_out}, {31'd0, mvalid});
                for (int i = 0; i < 10; i++) begin
                    check($sformatf("pins_x[%0d]", i), {21'd0, pins_x[i]}, mx[i] >>> 8);
                    check($sformatf("pins_y[%0d]", i), {22'd0, pins_y[i]}, my[i] >>> 8);
                    e16 = mvx[i][15:0];
                    check($sformatf("pins_vx[%0d]", i), {16'd0, pins_vx[i]}, {16'd0, e16});
                    e16 = mvy[i][15:0];
                    check($sformatf("pins_vy[%0d]", i), {16'd0, pins_vy[i]}, {16'd0, e16});
                    check($sformatf("pins_down[%0d]", i), {31'd0, pins_down[i]}, {31'd0, mdown[i]});
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic capture(input int pin, input logic [15:0] vx, input logic [15:0] vy);
        @(negedge clk_in);
        done_in = 1'b1;
        hit_in  = 10'(1 << pin);
        vx_in   = '0;
        vy_in   = '0;
        vx_in[pin] = vx;
        vy_in[pin] = vy;
        @(negedge clk_in);
        done_in = 1'b0;
        hit_in  = '0;
    endtask

    task automatic wait_valid(inout int lat);
        while (!valid_out && lat < 40) begin
            @(posedge clk_in);
            #1;
            lat++;
        end
        if (!valid_out) check("valid_out_timeout", 32'd0, 32'd1);
        @(negedge clk_in);
    endtask

    // Tick counts as cycle 1; valid_out is expected in cycle 11.
    task automatic run_frame(output int lat);
        @(negedge clk_in);
        frame_tick = 1'b1;
        @(posedge clk_in);
        #1;
        lat = 1;
        @(negedge clk_in);
        frame_tick = 1'b0;
        wait_valid(lat);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int lat;
        repeat (2) @(posedge clk_in);
        #1;
        cmp_en = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        #1;
        check("reset pins_x[0]", {21'd0, pins_x[0]}, 32'd512);
        check("reset pins_y[0]", {22'd0, pins_y[0]}, 32'd200);
        check("reset pins_x[9]", {21'd0, pins_x[9]}, 32'd584);
        check("reset pins_y[9]", {22'd0, pins_y[9]}, 32'd74);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset pins_down", {22'd0, pins_down}, 32'd0);
        check("reset pins_vx[0]", {16'd0, pins_vx[0]}, 32'd0);

        // Hit on head pin, one frame.
        capture(0, 16'h0200, 16'h0000);
        run_frame(lat);
        check("latency", lat, 32'd11);
        check("hit pins_x[0]", {21'd0, pins_x[0]}, 32'd514);
        check("hit pins_vx[0]", {16'd0, pins_vx[0]}, 32'h01E0);

        // Negative velocity on pin 6.
        capture(6, 16'h0000, 16'hFF00);
        run_frame(lat);
        check("neg pins_y[6]", {22'd0, pins_y[6]}, 32'd73);
        check("neg pins_vy[6]", {16'd0, pins_vy[6]}, 32'hFF10);
        check("coast pins_x[0]", {21'd0, pins_x[0]}, 32'd515);

        // Deadband: a slow pin creeps a fraction and stops.
        capture(3, 16'h000F, 16'h0000);
        run_frame(lat);
        check("deadband pins_x[3]", {21'd0, pins_x[3]}, 32'd464);
        check("deadband pins_vx[3]", {16'd0, pins_vx[3]}, 32'd0);
        run_frame(lat);
        check("deadband rest pins_x[3]", {21'd0, pins_x[3]}, 32'd464);

        // Off-lane: pin 6 driven off the top edge, then later hits ignored.
        capture(6, 16'h0000, 16'hB000);
        run_frame(lat);
        check("off pins_down", {22'd0, pins_down}, 32'h040);
        check("off pins_x[6]", {21'd0, pins_x[6]}, 32'd2047);
        check("off pins_y[6]", {22'd0, pins_y[6]}, 32'd1023);
        check("off pins_vx[6]", {16'd0, pins_vx[6]}, 32'd0);
        check("off pins_vy[6]", {16'd0, pins_vy[6]}, 32'd0);
        capture(6, 16'h0100, 16'h0100);
        run_frame(lat);
        check("off ignore pins_x[6]", {21'd0, pins_x[6]}, 32'd2047);
        check("off ignore pins_vx[6]", {16'd0, pins_vx[6]}, 32'd0);

        // Second frame_tick while busy must not start another pass.
        @(negedge clk_in);
        frame_tick = 1'b1;
        @(negedge clk_in);
        frame_tick = 1'b0;
        repeat (4) @(negedge clk_in);
        frame_tick = 1'b1;
        @(negedge clk_in);
        frame_tick = 1'b0;
        lat = 0;
        wait_valid(lat);
        repeat (3) @(negedge clk_in);
        check("no extra pass busy", {31'd0, busy}, 32'd0);

        // Capture for pin 2 landing in pin 2's own update cycle.
        capture(2, 16'h0100, 16'h0000);
        @(negedge clk_in);
        frame_tick = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        frame_tick = 1'b0;
        @(posedge clk_in);
        @(posedge clk_in);
        @(negedge clk_in);
        done_in = 1'b1;
        hit_in  = 10'h004;
        vx_in   = '0;
        vy_in   = '0;
        vx_in[2] = 16'h0300;
        @(negedge clk_in);
        done_in = 1'b0;
        hit_in  = '0;
        lat = 0;
        wait_valid(lat);
        check("race pins_x[2]", {21'd0, pins_x[2]}, 32'd537);
        check("race pins_vx[2]", {16'd0, pins_vx[2]}, 32'h00F0);
        run_frame(lat);
        check("race next pins_x[2]", {21'd0, pins_x[2]}, 32'd540);
        check("race next pins_vx[2]", {16'd0, pins_vx[2]}, 32'h02D0);

        // Reset in the middle of a pass.
        @(negedge clk_in);
        frame_tick = 1'b1;
        @(negedge clk_in);
        frame_tick = 1'b0;
        repeat (3) @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        check("midrst busy", {31'd0, busy}, 32'd0);
        check("midrst pins_x[0]", {21'd0, pins_x[0]}, 32'd512);
        check("midrst pins_y[6]", {22'd0, pins_y[6]}, 32'd74);
        check("midrst pins_down", {22'd0, pins_down}, 32'd0);
        repeat (2) @(negedge clk_in);
        check("midrst hold busy", {31'd0, busy}, 32'd0);
        check("midrst hold pins_x[2]", {21'd0, pins_x[2]}, 32'd536);
        rst_in = 1'b0;

        // Normal operation after reset.
        capture(0, 16'h0200, 16'h0000);
        run_frame(lat);
        check("post rst latency", lat, 32'd11);
        check("post rst pins_x[0]", {21'd0, pins_x[0]}, 32'd514);

        repeat (2) @(negedge clk_in);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
